id_display_reader: RTL

Reads the 3-bit pig ID address produced by the key-driven ID counter, looks up the 4-digit BCD ID from an internal 8-entry ROM, and drives a multiplexed 4-digit seven-segment display.
- The block sits on the system clock.
- It is the consumer side of the `id_addr` interface: the counter writes the address, this block reads it.
- `id_addr` arrives from the `clk_key1` domain, so the block synchronises it and accepts it only once it is stable.

---
 rtl/id_display_reader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/id_display_reader.sv
// id_display_reader
// Synchronises the 3-bit pig ID address from the key-clock domain. Once the
// address is stable, the block looks up the 4-digit BCD ID in an 8-entry ROM.
// It then scans that ID onto a multiplexed 4-digit seven-segment display.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   id_addr  ROM address from the ID counter (asynchronous to clk)
//   seg      segments {g,f,e,d,c,b,a}, active-low, registered
//   an       digit enables, active-low one-hot, an[0] = least-significant digit
//   id_word  displayed ID as 4 BCD nibbles, [15:12] = most-significant digit
//   new_id   1-cycle pulse on the edge where id_word updates
module id_display_reader #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_addr,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [15:0] id_word,
  output logic        new_id
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;

  state_t        state;
  logic [2:0]    s1, s2, s3, addr_q, rom_addr;
  logic [15:0]   rom_q;
  logic [CW-1:0] cnt;
  logic [1:0]    idx, idx_show;
  logic          wrap;

  // Entry k holds BCD of 1000 + 111*k, i.e. digits 1,k,k,k.
  function automatic logic [15:0] rom_lookup(input logic [2:0] a);
    case (a)
      3'd0:    rom_lookup = 16'h1000;
      3'd1:    rom_lookup = 16'h1111;
      3'd2:    rom_lookup = 16'h1222;
      3'd3:    rom_lookup = 16'h1333;
      3'd4:    rom_lookup = 16'h1444;
      3'd5:    rom_lookup = 16'h1555;
      3'd6:    rom_lookup = 16'h1666;
      default: rom_lookup = 16'h1777;
    endcase
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // A digit is blanked when it and every higher digit are zero.
  // Digit 0 is never blanked, so an ID of 0000 still shows "0".
  function automatic logic [6:0] digit_seg(input logic [15:0] w, input logic [1:0] i);
    logic lz;
    case (i)
      2'd3:    lz = (w[15:12] == 4'h0);
      2'd2:    lz = (w[15:8]  == 8'h00);
      2'd1:    lz = (w[15:4]  == 12'h000);
      default: lz = 1'b0;
    endcase
    digit_seg = (BLANK_LZ && lz) ? 7'h7F : seg7(w[i*4 +: 4]);
  endfunction

  // At a wrap, the display jumps straight to the next digit. This keeps an and
  // seg changing only once per scan step.
  always_comb begin
    wrap     = (cnt == CNT_LAST);
    idx_show = wrap ? idx + 2'd1 : idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      addr_q   <= '0;
      rom_addr <= '0;
      rom_q    <= '0;
      state    <= FETCH;   // reload entry 0 straight out of reset
      id_word  <= '0;
      new_id   <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
      an       <= 4'b1111;
      seg      <= 7'h7F;
    end else begin
      s1     <= id_addr;
      s2     <= s1;
      s3     <= s2;
      rom_q  <= rom_lookup(rom_addr);
      new_id <= 1'b0;

      case (state)
        // s2 == s3 rejects single-cycle glitches. Changes that arrive while a
        // fetch is in progress are picked up here once the FSM returns to IDLE.
        IDLE: if (s2 == s3 && s3 != addr_q) begin
          addr_q   <= s3;
          rom_addr <= s3;
          state    <= FETCH;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          id_word <= rom_q;
          new_id  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (wrap) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Refresh the display at a scan wrap, and once on the edge after
      // id_word has changed (new_id is high for that edge).
      if (wrap || new_id) begin
        an  <= ~(4'b0001 << idx_show);
        seg <= digit_seg(id_word, idx_show);
      end
    end
  end

endmodule
